// File: rtl/sdram_arbiter.sv
// sdram_arbiter
// Shares the single SDRAM controller command port between NUM_REQ requesters
// (0 = icache, 1 = dcache, 2 = blitter/VGA). One pending request is chosen by
// round-robin and forwarded to the controller. The command ack goes back to the
// owner. Each in-order read return is steered back to the requester that issued
// it, using a small FIFO of owner tags.
//
// Ports
//   clock, reset             system clock, synchronous active-high reset
//   req_request/_write       per-requester request valid and direction
//   req_addr/_byte_enable/   per-requester command fields, slice i belongs to
//   req_wdata                requester i
//   req_ack                  one-cycle pulse to the owner when the controller
//                            accepts its command
//   req_rdvalid/req_rdata    routed read return (rdata is zero when idle)
//   sdram_*                  command interface to the SDRAM controller
//   sdram_rdvalid/_rdata     in-order read data from the controller
//   rd_error                 sticky: read data arrived with no read outstanding
module sdram_arbiter #(
    parameter int NUM_REQ  = 3,
    parameter int RD_DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_request,
    input  logic [NUM_REQ*26-1:0] req_addr,
    input  logic [NUM_REQ-1:0]    req_write,
    input  logic [NUM_REQ*4-1:0]  req_byte_enable,
    input  logic [NUM_REQ*32-1:0] req_wdata,
    output logic [NUM_REQ-1:0]    req_ack,
    output logic [NUM_REQ-1:0]    req_rdvalid,
    output logic [31:0]           req_rdata,
    output logic                  sdram_request,
    output logic [25:0]           sdram_addr,
    output logic                  sdram_write,
    output logic [3:0]            sdram_byte_enable,
    output logic [31:0]           sdram_wdata,
    input  logic                  sdram_ack,
    input  logic [31:0]           sdram_rdata,
    input  logic                  sdram_rdvalid,
    output logic                  rd_error
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PW = (RD_DEPTH > 1) ? $clog2(RD_DEPTH) : 1;
    localparam int CW = $clog2(RD_DEPTH + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state_q;
    logic [IW-1:0]   owner_q;
    logic [IW-1:0]   ptr_q;
    logic            sdramRequest_q;
    logic [25:0]     sdramAddr_q;
    logic            sdramWrite_q;
    logic [3:0]      sdramBe_q;
    logic [31:0]     sdramWdata_q;

    logic [IW-1:0]   tag_q [RD_DEPTH];
    logic [PW-1:0]   wrPtr_q;
    logic [PW-1:0]   rdPtr_q;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;
    logic            rdError_q;

    logic               fifoFull;
    logic               fifoEmpty;
    logic               ackFire;
    logic               push;
    logic               pop;
    logic [NUM_REQ-1:0] eligible;
    logic               winFound;
    logic [IW-1:0]      winIdx;
    logic [IW-1:0]      cand;
    logic [25:0]        winAddr;
    logic               winWrite;
    logic [3:0]         winBe;
    logic [31:0]        winWdata;

    assign fifoFull  = (count_q == CW'(RD_DEPTH));
    assign fifoEmpty = (count_q == '0);
    assign ackFire   = (state_q == BUSY) && sdram_ack;
    assign push      = ackFire && !sdramWrite_q;
    assign pop       = sdram_rdvalid && !fifoEmpty;

    // A read may only be granted while a tag slot is free, so a read sitting in
    // BUSY can always push its tag when the controller accepts it.
    assign eligible = req_request & (req_write | {NUM_REQ{!fifoFull}});

    // Round-robin search starting at the pointer; first eligible index wins.
    always_comb begin
        winFound = 1'b0;
        winIdx   = '0;
        cand     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IW'((int'(ptr_q) + k) % NUM_REQ);
            if (!winFound && eligible[cand]) begin
                winFound = 1'b1;
                winIdx   = cand;
            end
        end
    end

    // Field mux for the winner, written with constant slices.
    always_comb begin
        winAddr  = '0;
        winWrite = 1'b0;
        winBe    = '0;
        winWdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winIdx == IW'(i)) begin
                winAddr  = req_addr[26*i +: 26];
                winWrite = req_write[i];
                winBe    = req_byte_enable[4*i +: 4];
                winWdata = req_wdata[32*i +: 32];
            end
        end
    end

    // Command FSM. The sdram_* fields are registered at grant and held until
    // the controller acks; the pointer then moves past the owner.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            owner_q        <= '0;
            ptr_q          <= '0;
            sdramRequest_q <= 1'b0;
            sdramAddr_q    <= '0;
            sdramWrite_q   <= 1'b0;
            sdramBe_q      <= '0;
            sdramWdata_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (winFound) begin
                        owner_q        <= winIdx;
                        sdramAddr_q    <= winAddr;
                        sdramWrite_q   <= winWrite;
                        sdramBe_q      <= winBe;
                        sdramWdata_q   <= winWdata;
                        sdramRequest_q <= 1'b1;
                        state_q        <= BUSY;
                    end
                end
                BUSY: begin
                    if (sdram_ack) begin
                        sdramRequest_q <= 1'b0;
                        ptr_q          <= (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
                        state_q        <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Simultaneous push and pop leave the occupancy unchanged.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Read-tag FIFO. Depth is a power of two so the pointers wrap naturally.
    always_ff @(posedge clock) begin
        if (reset) begin
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            count_q   <= '0;
            rdError_q <= 1'b0;
        end else begin
            if (push) begin
                tag_q[wrPtr_q] <= owner_q;
                wrPtr_q        <= wrPtr_q + 1'b1;
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            count_q <= count_d;
            if (sdram_rdvalid && fifoEmpty) begin
                rdError_q <= 1'b1;
            end
        end
    end

    // Ack and read return are steered in the same cycle they arrive.
    always_comb begin
        req_ack     = '0;
        req_rdvalid = '0;
        req_rdata   = '0;
        if (ackFire) begin
            req_ack[owner_q] = 1'b1;
        end
        if (pop) begin
            req_rdvalid[tag_q[rdPtr_q]] = 1'b1;
            req_rdata                   = sdram_rdata;
        end
    end

    assign sdram_request     = sdramRequest_q;
    assign sdram_addr        = sdramAddr_q;
    assign sdram_write       = sdramWrite_q;
    assign sdram_byte_enable = sdramBe_q;
    assign sdram_wdata       = sdramWdata_q;
    assign rd_error          = rdError_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter
// Directed bench for sdram_arbiter. A transaction-level model (current command,
// round-robin pointer, queue of read owners) predicts every output each cycle;
// directed scenarios add hand-computed literal expectations.
`timescale 1ns/1ps
module tb_sdram_arbiter;

    localparam int N = 3;
    localparam int D = 4;

    logic            clock;
    logic            reset;
    logic [N-1:0]    req_request;
    logic [N*26-1:0] req_addr;
    logic [N-1:0]    req_write;
    logic [N*4-1:0]  req_byte_enable;
    logic [N*32-1:0] req_wdata;
    logic [N-1:0]    req_ack;
    logic [N-1:0]    req_rdvalid;
    logic [31:0]     req_rdata;
    logic            sdram_request;
    logic [25:0]     sdram_addr;
    logic            sdram_write;
    logic [3:0]      sdram_byte_enable;
    logic [31:0]     sdram_wdata;
    logic            sdram_ack;
    logic [31:0]     sdram_rdata;
    logic            sdram_rdvalid;
    logic            rd_error;

    int checks = 0;
    int errors = 0;

    sdram_arbiter #(.NUM_REQ(N), .RD_DEPTH(D)) dut (
        .clock(clock), .reset(reset),
        .req_request(req_request), .req_addr(req_addr), .req_write(req_write),
        .req_byte_enable(req_byte_enable), .req_wdata(req_wdata),
        .req_ack(req_ack), .req_rdvalid(req_rdvalid), .req_rdata(req_rdata),
        .sdram_request(sdram_request), .sdram_addr(sdram_addr),
        .sdram_write(sdram_write), .sdram_byte_enable(sdram_byte_enable),
        .sdram_wdata(sdram_wdata), .sdram_ack(sdram_ack),
        .sdram_rdata(sdram_rdata), .sdram_rdvalid(sdram_rdvalid),
        .rd_error(rd_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Model state
    bit          mValid = 1'b0;
    bit          mBusy;
    int          mOwner;
    int          mPtr;
    int          mTags[$];
    bit          mErr;
    logic [25:0] mAddr;
    bit          mWrite;
    logic [3:0]  mBe;
    logic [31:0] mWdata;
    bit          mFull;
    bit          mPopNow;
    bit          mPushNow;
    int          mPushTag;
    int          mCand;

    // Model update on every edge, from the inputs the DUT samples at that edge.
    always @(posedge clock) begin
        if (reset) begin
            mValid = 1'b1;
            mBusy  = 1'b0;
            mOwner = 0;
            mPtr   = 0;
            mTags.delete();
            mErr   = 1'b0;
        end else if (mValid) begin
            mFull    = (mTags.size() == D);
            mPopNow  = sdram_rdvalid && (mTags.size() > 0);
            mPushNow = 1'b0;
            if (sdram_rdvalid && mTags.size() == 0) mErr = 1'b1;
            if (mBusy) begin
                if (sdram_ack) begin
                    mPushNow = !mWrite;
                    mPushTag = mOwner;
                    mBusy    = 1'b0;
                    mPtr     = (mOwner + 1) % N;
                end
            end else begin
                for (int k = 0; k < N; k++) begin
                    mCand = (mPtr + k) % N;
                    if (!mBusy && req_request[mCand] && (req_write[mCand] || !mFull)) begin
                        mBusy  = 1'b1;
                        mOwner = mCand;
                        mAddr  = req_addr[26*mCand +: 26];
                        mWrite = req_write[mCand];
                        mBe    = req_byte_enable[4*mCand +: 4];
                        mWdata = req_wdata[32*mCand +: 32];
                    end
                end
            end
            if (mPopNow) void'(mTags.pop_front());
            if (mPushNow) mTags.push_back(mPushTag);
        end
    end

    logic [N-1:0] expAck;
    logic [N-1:0] expRv;
    logic [31:0]  expRd;

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin
        if (mValid) begin
            expAck = '0;
            expRv  = '0;
            expRd  = '0;
            if (mBusy && sdram_ack) expAck[mOwner] = 1'b1;
            if (sdram_rdvalid && mTags.size() > 0) begin
                expRv[mTags[0]] = 1'b1;
                expRd           = sdram_rdata;
            end
            checkOutput("cyc_sdram_request", sdram_request, mBusy);
            if (mBusy) begin
                checkOutput("cyc_sdram_addr", sdram_addr, mAddr);
                checkOutput("cyc_sdram_write", sdram_write, mWrite);
                checkOutput("cyc_sdram_be", sdram_byte_enable, mBe);
                checkOutput("cyc_sdram_wdata", sdram_wdata, mWdata);
            end
            checkOutput("cyc_req_ack", req_ack, expAck);
            checkOutput("cyc_req_rdvalid", req_rdvalid, expRv);
            checkOutput("cyc_req_rdata", req_rdata, expRd);
            checkOutput("cyc_rd_error", rd_error, mErr);
        end
    end

    // Requester and controller helpers
    bit           autoAck = 1'b0;
    bit           autoDrop = 1'b1;
    int           ackWait = 0;
    int           hiCnt = 0;
    logic [N-1:0] ackAtNeg = '0;
    bit           recording = 1'b0;
    int           grantQ[$];

    always @(negedge clock) begin
        ackAtNeg = req_ack;
        if (recording) begin
            for (int i = 0; i < N; i++) if (req_ack[i]) grantQ.push_back(i);
        end
    end

    // Requesters drop after their ack; the controller acks after ackWait+1 cycles.
    always @(posedge clock) begin
        #1;
        if (autoDrop) req_request = req_request & ~ackAtNeg;
        hiCnt = sdram_request ? hiCnt + 1 : 0;
        if (autoAck) sdram_ack = sdram_request && (hiCnt > ackWait);
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic applyStimulus(input int idx, input bit wr, input logic [25:0] addr,
                                 input logic [3:0] be, input logic [31:0] wdata);
        req_addr[26*idx +: 26]       = addr;
        req_write[idx]               = wr;
        req_byte_enable[4*idx +: 4]  = be;
        req_wdata[32*idx +: 32]      = wdata;
        req_request[idx]             = 1'b1;
    endtask

    task automatic waitAck(input int idx, input int budget, input string name);
        int n = 0;
        logic [N-1:0] want;
        want = '0;
        want[idx] = 1'b1;
        do begin
            @(negedge clock);
            n++;
        end while (req_ack == '0 && n < budget);
        checkOutput(name, req_ack, want);
    endtask

    task automatic pulseRdvalid(input logic [31:0] data, input logic [N-1:0] want, input string name);
        sdram_rdvalid = 1'b1;
        sdram_rdata   = data;
        @(negedge clock);
        checkOutput({name, "_rdvalid"}, req_rdvalid, want);
        checkOutput({name, "_rdata"}, req_rdata, data);
        tick();
        sdram_rdvalid = 1'b0;
        sdram_rdata   = '0;
    endtask

    task automatic doReset();
        reset       = 1'b1;
        req_request = '0;
        sdram_ack   = 1'b0;
        autoAck     = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    int rrExp[6] = '{0, 1, 2, 0, 1, 2};
    int budgetLeft;

    initial begin
        reset = 1'b1;
        req_request = '0; req_addr = '0; req_write = '0;
        req_byte_enable = '0; req_wdata = '0;
        sdram_ack = 1'b0; sdram_rdata = '0; sdram_rdvalid = 1'b0;
        tick();
        tick();
        @(negedge clock);
        checkOutput("reset_sdram_request", sdram_request, 0);
        checkOutput("reset_sdram_addr", sdram_addr, 0);
        checkOutput("reset_sdram_write", sdram_write, 0);
        checkOutput("reset_sdram_be", sdram_byte_enable, 0);
        checkOutput("reset_sdram_wdata", sdram_wdata, 0);
        checkOutput("reset_req_ack", req_ack, 0);
        checkOutput("reset_req_rdvalid", req_rdvalid, 0);
        checkOutput("reset_req_rdata", req_rdata, 0);
        checkOutput("reset_rd_error", rd_error, 0);
        tick();
        reset = 1'b0;

        // Single read from requester 1
        autoAck = 1'b1; ackWait = 1;
        applyStimulus(1, 1'b0, 26'h0001234, 4'hF, 32'h0);
        waitAck(1, 20, "single_ack");
        checkOutput("single_sdram_addr", sdram_addr, 26'h0001234);
        checkOutput("single_sdram_write", sdram_write, 0);
        repeat (5) tick();
        pulseRdvalid(32'hDEADBEEF, 3'b010, "single");
        checkOutput("single_model_fifo_empty", mTags.size(), 0);

        // Round-robin with all three holding writes
        doReset();
        autoAck = 1'b1; ackWait = 0; autoDrop = 1'b0;
        grantQ.delete();
        recording = 1'b1;
        applyStimulus(0, 1'b1, 26'h0000100, 4'h1, 32'h00000010);
        applyStimulus(1, 1'b1, 26'h0000200, 4'h3, 32'h00000020);
        applyStimulus(2, 1'b1, 26'h0000300, 4'hC, 32'h00000030);
        budgetLeft = 80;
        while (grantQ.size() < 6 && budgetLeft > 0) begin
            @(posedge clock);
            budgetLeft--;
        end
        #2;
        req_request = '0;
        recording = 1'b0;
        autoDrop = 1'b1;
        for (int j = 0; j < 6; j++) begin
            checkOutput($sformatf("rr_grant%0d", j),
                        (j < grantQ.size()) ? grantQ[j] : -1, rrExp[j]);
        end
        tick();
        tick();

        // Read return routing: reads from 2, 0, 1
        doReset();
        autoAck = 1'b1; ackWait = 0;
        applyStimulus(2, 1'b0, 26'h0002000, 4'hF, 32'h0);
        waitAck(2, 20, "route_ack2");
        tick(); tick();
        applyStimulus(0, 1'b0, 26'h0000040, 4'hF, 32'h0);
        waitAck(0, 20, "route_ack0");
        tick(); tick();
        applyStimulus(1, 1'b0, 26'h0001080, 4'hF, 32'h0);
        waitAck(1, 20, "route_ack1");
        tick(); tick();
        pulseRdvalid(32'h0000000A, 3'b100, "route_a");
        pulseRdvalid(32'h0000000B, 3'b001, "route_b");
        pulseRdvalid(32'h0000000C, 3'b010, "route_c");

        // FIFO full: four reads 0,1,0,2 leave pointer at 0
        doReset();
        autoAck = 1'b1; ackWait = 0;
        applyStimulus(0, 1'b0, 26'h0000010, 4'hF, 32'h0); waitAck(0, 20, "fill_0"); tick(); tick();
        applyStimulus(1, 1'b0, 26'h0000020, 4'hF, 32'h0); waitAck(1, 20, "fill_1"); tick(); tick();
        applyStimulus(0, 1'b0, 26'h0000030, 4'hF, 32'h0); waitAck(0, 20, "fill_2"); tick(); tick();
        applyStimulus(2, 1'b0, 26'h0000040, 4'hF, 32'h0); waitAck(2, 20, "fill_3"); tick(); tick();
        checkOutput("full_model_count", mTags.size(), 4);
        applyStimulus(0, 1'b0, 26'h0000AA0, 4'hF, 32'h0);
        applyStimulus(1, 1'b1, 26'h0000BB0, 4'h5, 32'h12345678);
        waitAck(1, 20, "full_write_first");
        checkOutput("full_write_dir", sdram_write, 1);
        checkOutput("full_write_data", sdram_wdata, 32'h12345678);
        tick(); tick(); tick();
        @(negedge clock);
        checkOutput("full_read_blocked", {sdram_request, req_ack}, 0);
        tick();
        pulseRdvalid(32'h00000011, 3'b001, "full_pop");
        waitAck(0, 20, "full_read_after_pop");
        tick();
        // Tags now 1,0,2,0
        pulseRdvalid(32'h00000022, 3'b010, "pp_pre");

        // Push and pop in the same cycle
        autoAck = 1'b0; sdram_ack = 1'b0;
        applyStimulus(1, 1'b0, 26'h0000CC0, 4'hF, 32'h0);
        tick();
        sdram_ack = 1'b1;
        sdram_rdvalid = 1'b1;
        sdram_rdata = 32'h00000033;
        @(negedge clock);
        checkOutput("pp_ack", req_ack, 3'b010);
        checkOutput("pp_rdvalid", req_rdvalid, 3'b001);
        checkOutput("pp_rdata", req_rdata, 32'h00000033);
        tick();
        sdram_ack = 1'b0; sdram_rdvalid = 1'b0; sdram_rdata = '0;
        // Exactly three tags remain: 2,0,1
        pulseRdvalid(32'h00000044, 3'b100, "pp_drain0");
        pulseRdvalid(32'h00000055, 3'b001, "pp_drain1");
        pulseRdvalid(32'h00000066, 3'b010, "pp_drain2");

        // rdvalid with empty FIFO
        sdram_rdvalid = 1'b1; sdram_rdata = 32'h00000077;
        @(negedge clock);
        checkOutput("err_no_rdvalid", req_rdvalid, 0);
        checkOutput("err_rdata_zero", req_rdata, 0);
        tick();
        sdram_rdvalid = 1'b0; sdram_rdata = '0;
        @(negedge clock);
        checkOutput("err_sticky", rd_error, 1);
        tick();

        // sdram_ack while idle is ignored
        sdram_ack = 1'b1;
        @(negedge clock);
        checkOutput("idle_ack_ignored", req_ack, 0);
        tick();
        sdram_ack = 1'b0;

        // Reset in BUSY with a tag outstanding and pointer at 2
        applyStimulus(1, 1'b0, 26'h0000DD0, 4'hF, 32'h0);
        tick();
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        tick();
        applyStimulus(0, 1'b1, 26'h0000EE0, 4'hF, 32'hCAFEF00D);
        tick();
        @(negedge clock);
        checkOutput("rst_busy_before", sdram_request, 1);
        tick();
        reset = 1'b1;
        req_request = '0;
        tick();
        reset = 1'b0;
        @(negedge clock);
        checkOutput("rst_sdram_request", sdram_request, 0);
        checkOutput("rst_rd_error", rd_error, 0);
        checkOutput("rst_req_ack", req_ack, 0);
        tick();
        autoAck = 1'b1; ackWait = 0;
        applyStimulus(0, 1'b0, 26'h0000F00, 4'hF, 32'h0);
        applyStimulus(2, 1'b0, 26'h0000F20, 4'hF, 32'h0);
        waitAck(0, 20, "rst_ptr_zero");
        tick();
        waitAck(2, 20, "rst_next_2");
        tick();
        pulseRdvalid(32'h00000088, 3'b001, "rst_fifo_cleared");
        pulseRdvalid(32'h00000099, 3'b100, "rst_second");
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
Shares the single SDRAM controller port between NUM_REQ requesters: CPU I-cache, CPU D-cache and the blitter/VGA fetcher.
- Selects one pending request at a time by round-robin and forwards it to the SDRAM controller.
- Returns the write/command ack to the requester that owns the command.
- Routes each in-order read-data return (rdvalid) back to the requester that issued that read, using a tag FIFO.
- Sits between the cache/DMA blocks and the SDRAM controller.

Parameters:
NUM_REQ, 3, number of requesters; index 0 = icache, 1 = dcache, 2 = blitter.
RD_DEPTH, 4, maximum outstanding reads (tag FIFO depth, power of 2).

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
req_request  in  NUM_REQ  per-requester request; held high until that requester's ack
req_addr  in  NUM_REQ*26  per-requester address, slice i = [26*i+25:26*i]
req_write  in  NUM_REQ  1 = write, 0 = read
req_byte_enable  in  NUM_REQ*4  per-requester byte enables
req_wdata  in  NUM_REQ*32  per-requester write data
req_ack  out  NUM_REQ  one-cycle pulse to the owner when SDRAM accepts its command
req_rdvalid  out  NUM_REQ  one-cycle pulse to the requester whose read data is on req_rdata
req_rdata  out  32  read data; zero when no rdvalid
sdram_request  out  1  command valid to SDRAM controller; held until sdram_ack
sdram_addr  out  26  command address
sdram_write  out  1  command direction
sdram_byte_enable  out  4  command byte enables
sdram_wdata  out  32  command write data
sdram_ack  in  1  controller accepted the command
sdram_rdata  in  32  read data
sdram_rdvalid  in  1  read data valid; reads return in issue order
rd_error  out  1  sticky: rdvalid arrived while tag FIFO was empty

Behaviour:
- Reset values: all outputs 0, state IDLE, round-robin pointer = 0, tag FIFO empty, rd_error = 0.
- Reset mid-transaction abandons the command and all outstanding tags; the SDRAM controller is reset on the same signal.
- FSM states:
  - IDLE: choose the winner from eligible requests. Eligible = req_request[i] && (req_write[i] || FIFO not full).
  - Search order starts at the pointer and wraps modulo NUM_REQ. The first eligible index wins.
  - On a winner: register owner = i, capture its addr/write/be/wdata into the sdram_* registers, set sdram_request = 1, go to BUSY.
  - If no request is eligible, stay in IDLE.
  - BUSY: hold sdram_request and all sdram_* fields stable until sdram_ack.
  - In the sdram_ack cycle: req_ack[owner] = 1 (combinational, same cycle); registered sdram_request drops to 0 on the next edge; pointer = owner+1 mod NUM_REQ; go to IDLE.
- Latency: a request seen in cycle N gives sdram_request high in cycle N+1. Minimum gap between consecutive commands is one IDLE cycle.
- Requesters must keep request and fields stable until their ack, and deassert the cycle after ack. A request still asserted in IDLE after its ack is treated as a new request; this is the requester's bug.
- Read tagging:
  - On sdram_ack with sdram_write = 0, push owner into the tag FIFO.
  - On sdram_rdvalid, pop the FIFO head h, pulse req_rdvalid[h] and drive req_rdata = sdram_rdata the same cycle (combinational).
  - Push and pop in the same cycle are both performed; occupancy is unchanged.
  - Pointers wrap modulo RD_DEPTH. Count runs 0..RD_DEPTH.
- FIFO boundaries:
  - When full, read requests are not granted; writes are still granted.
  - A read already in BUSY is guaranteed a slot, because it was only granted when the FIFO was not full.
  - sdram_rdvalid with the FIFO empty: no req_rdvalid, set rd_error (sticky until reset), FIFO unchanged.
- Writes produce no tag and no rdvalid. The requester's ack completes the write.
- sdram_ack outside BUSY is ignored; no req_ack is produced.

Test Plan:
- Single read: requester 1 reads 0x0001234; SDRAM acks 2 cycles after the request and rdvalid carries 0xDEADBEEF 5 cycles later -> req_ack = 3'b010 for one cycle, sdram_addr = 0x0001234, req_rdvalid = 3'b010 with req_rdata = 0xDEADBEEF, FIFO empty at end.
- Round-robin: all three requesters hold requests from reset, SDRAM acks every command in 1 cycle -> grant order 0,1,2,0,1,2; no requester is ever granted twice while another is waiting.
- Read return routing: reads issued by requesters 2, 0, 1 in that order, then three rdvalids with data 0xA, 0xB, 0xC -> req_rdvalid pulses 3'b100, 3'b001, 3'b010 with matching data.
- FIFO full: RD_DEPTH = 4, issue 4 reads with no rdvalid; requester 0 reads and requester 1 writes -> requester 1's write is granted, requester 0 waits. After one rdvalid, requester 0 is granted.
- Simultaneous push/pop: a read's sdram_ack coincides with an rdvalid for an earlier read -> the correct rdvalid is routed and FIFO count is unchanged.
- Error and reset: rdvalid with the FIFO empty -> rd_error = 1 and no req_rdvalid. Reset asserted while in BUSY -> next cycle sdram_request = 0, rd_error = 0, FIFO empty, pointer = 0.
